gmii_frame_gen_chk: RTL
=======================

Name: gmii_frame_gen_chk

Overview:
- Synthesizable GMII-side traffic generator and checker for exercising the PCS transmit/receive paths.
- Replaces the behavioural stimulus tester with a reusable, parametrised BIST block.
- TX side drives TXD/TX_EN/TX_ER into the PCS with configurable payload length, frame count, inter-packet gap and payload pattern.
- RX side parses RXD/RX_DV/RX_ER from the PCS (e.g. in loopback), regenerates the expected payload and counts received frames and errored frames.

Parameters:
- PREAMBLE_LEN, 7, number of 0x55 bytes sent before SFD.
- IPG_LEN, 12, idle cycles (TX_EN=0) after each frame.
- LEN_W, 11, width of frame_len.
- CNT_W, 16, width of num_frames and of all status counters.

Ports:
- GTX_CLK  in  1  single clock for TX and RX sides.
- mr_main_reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run when idle.
- stop  in  1  level; finish the current frame and IPG, then go idle.
- frame_len  in  LEN_W  payload bytes per frame; 0 is treated as 1.
- num_frames  in  CNT_W  frames per run; 0 means continuous until stop.
- mode  in  1  payload pattern: 0 = incrementing byte, 1 = LFSR.
- inject_err  in  1  pulse; arms a TX_ER on the first payload byte of the next frame.
- TXD  out  8  GMII transmit data.
- TX_EN  out  1  GMII transmit enable.
- TX_ER  out  1  GMII transmit error.
- RXD  in  8  GMII receive data.
- RX_DV  in  1  GMII receive data valid.
- RX_ER  in  1  GMII receive error.
- busy  out  1  high while a TX run is active.
- done  out  1  one-cycle pulse when a run ends.
- tx_frames  out  CNT_W  frames transmitted.
- rx_frames  out  CNT_W  frames received (SFD seen).
- err_count  out  CNT_W  errored received frames.

Behaviour:
- Reset:
  - All outputs are 0 on the first edge with mr_main_reset=1; both FSMs go idle and inject_err arming is cleared.
  - Reset mid-frame aborts immediately: TX_EN drops the next cycle, with no truncation handling.
- Run start:
  - start while busy=0 latches frame_len, num_frames and mode, and clears all three counters.
  - start while busy=1 is ignored.
- TX FSM states: IDLE, PRE, SFD, DATA, IPG.
  - IDLE→PRE on the cycle after start; busy=1 from that same cycle.
  - PRE: TX_EN=1, TXD=0x55 for PREAMBLE_LEN cycles.
  - SFD: TXD=0xD5 for 1 cycle.
  - DATA: frame_len cycles of payload.
  - IPG: TX_EN=0, TXD=0x00 for IPG_LEN cycles; tx_frames increments on entry to IPG.
  - IPG exit goes to PRE when frames remain and stop=0. Otherwise it goes to IDLE, with done=1 for one cycle and busy=0 from that cycle.
- Payload generation (restarts at each frame):
  - mode 0: byte i = i[7:0], so it wraps 0xFF→0x00.
  - mode 1: 8-bit LFSR seeded 0xFF. The current state is output, then the state advances to {s[6:0], s[7]^s[5]^s[4]^s[3]}.
- inject_err:
  - Sets an armed flag, cleared only by use or by reset.
  - The first DATA cycle after arming drives TX_ER=1 with valid data; TX_ER=0 in all other cycles.
- RX FSM states: R_IDLE, R_PRE, R_DATA, R_DROP.
  - Rising RX_DV → R_PRE.
  - In R_PRE, any count of 0x55 (including zero) is accepted. 0xD5 → R_DATA and rx_frames+1. Any other byte → R_DROP with the frame marked errored (it does not count in rx_frames).
  - In R_DATA, an independent generator using the latched mode compares each RXD against the expected byte.
  - A frame is errored on any of: a byte mismatch, RX_ER=1 while RX_DV=1, or a received byte count ≠ frame_len at RX_DV fall.
  - err_count increments at most once per frame, one cycle after RX_DV falls.
  - R_DROP waits for RX_DV=0 and then counts the error.
- Counters saturate at all-ones; they never wrap.
- RX operates regardless of busy, so frames arriving after done are still checked.

Test Plan:
1. Reset with mr_main_reset=1 for 2 cycles → TXD=0, TX_EN=0, TX_ER=0, busy=0, done=0, all counters=0.
2. TXD→RXD loopback, frame_len=4, num_frames=1, mode=0, start → 7×0x55, 0xD5, 00 01 02 03 with TX_EN=1 for 12 cycles; then 12 idle cycles; done pulses once; tx_frames=1, rx_frames=1, err_count=0.
3. mode=1, frame_len=3 → payload FF FE FC; loopback gives err_count=0.
4. num_frames=3, frame_len=2 → three frames, exactly 12 TX_EN=0 cycles between frames; tx_frames=3, rx_frames=3. Repeating with num_frames=0 and stop asserted mid-second frame → run ends after frame 2, tx_frames=2.
5. inject_err pulse before start, with TX_ER looped to RX_ER → TX_ER high on the first payload byte only; rx_frames=1, err_count=1.
6. RX-only stimulus:
   - Frame with byte 2 corrupted → err_count=1.
   - Frame truncated after 2 of 4 bytes → err_count=2.
   - Frame with 0x33 in the preamble → err_count=3, rx_frames unchanged.
   - Reset mid-DATA → TX_EN=0 next cycle and counters=0.

Source files
------------

// File: rtl/gmii_frame_gen_chk.sv
// GMII-side BIST: transmits preamble/SFD/payload frames with a programmable gap,
// and checks received frames against a regenerated payload, counting good and errored frames.
module gmii_frame_gen_chk #(
  parameter int PREAMBLE_LEN = 7,
  parameter int IPG_LEN      = 12,
  parameter int LEN_W        = 11,
  parameter int CNT_W        = 16
) (
  input  logic             GTX_CLK,
  input  logic             mr_main_reset,
  input  logic             start,
  input  logic             stop,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [CNT_W-1:0] num_frames,
  input  logic             mode,
  input  logic             inject_err,
  output logic [7:0]       TXD,
  output logic             TX_EN,
  output logic             TX_ER,
  input  logic [7:0]       RXD,
  input  logic             RX_DV,
  input  logic             RX_ER,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] tx_frames,
  output logic [CNT_W-1:0] rx_frames,
  output logic [CNT_W-1:0] err_count
);

  localparam int PC_MAX = (PREAMBLE_LEN > IPG_LEN) ? PREAMBLE_LEN : IPG_LEN;
  localparam int PC_W   = $clog2(PC_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SFD, S_DATA, S_IPG} tx_state_e;
  typedef enum logic [1:0] {R_IDLE, R_PRE, R_DATA, R_DROP} rx_state_e;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  tx_state_e        state_q, state_d;
  rx_state_e        rstate_q, rstate_d;
  logic [PC_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0] gen_idx_q, gen_idx_d;
  logic [7:0]       gen_lfsr_q, gen_lfsr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic             mode_q, mode_d;
  logic             armed_q, armed_d;
  logic [7:0]       txd_q, txd_d;
  logic             tx_en_q, tx_en_d;
  logic             tx_er_q, tx_er_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] tx_frames_q, tx_frames_d;
  logic [CNT_W-1:0] rx_frames_q, rx_frames_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [LEN_W-1:0] rx_idx_q, rx_idx_d;
  logic [7:0]       rx_lfsr_q, rx_lfsr_d;
  logic [LEN_W:0]   rx_cnt_q, rx_cnt_d;
  logic             rx_err_q, rx_err_d;
  logic             rx_dv_q;

  logic [LEN_W-1:0] len_eff_s;
  logic [7:0]       pay_s;
  logic [7:0]       exp_s;
  logic             more_s;
  logic             clr_s;
  logic             dv_rise_s;
  logic             pre_byte_s;

  assign len_eff_s = (len_q == {LEN_W{1'b0}}) ? LEN_W'(1) : len_q;
  assign pay_s     = mode_q ? gen_lfsr_q : gen_idx_q[7:0];
  assign exp_s     = mode_q ? rx_lfsr_q : rx_idx_q[7:0];
  // tx_frames already includes the frame just finished when IPG ends
  assign more_s    = (num_q == {CNT_W{1'b0}}) || (tx_frames_q < num_q);
  assign dv_rise_s = RX_DV & ~rx_dv_q;

  // TX sequencer: next state plus the registered GMII/status values for the next cycle
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gen_idx_d   = gen_idx_q;
    gen_lfsr_d  = gen_lfsr_q;
    len_d       = len_q;
    num_d       = num_q;
    mode_d      = mode_q;
    armed_d     = armed_q | inject_err;
    txd_d       = 8'h00;
    tx_en_d     = 1'b0;
    tx_er_d     = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tx_frames_d = tx_frames_q;
    clr_s       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d       = frame_len;
          num_d       = num_frames;
          mode_d      = mode;
          clr_s       = 1'b1;
          tx_frames_d = {CNT_W{1'b0}};
          state_d     = S_PRE;
          cnt_d       = {PC_W{1'b0}};
          tx_en_d     = 1'b1;
          txd_d       = 8'h55;
          busy_d      = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      S_PRE: begin
        tx_en_d    = 1'b1;
        gen_idx_d  = {LEN_W{1'b0}};
        gen_lfsr_d = 8'hFF;
        if (cnt_q == PC_W'(PREAMBLE_LEN - 1)) begin
          state_d = S_SFD;
          txd_d   = 8'hD5;
          cnt_d   = {PC_W{1'b0}};
        end else begin
          txd_d = 8'h55;
          cnt_d = cnt_q + PC_W'(1);
        end
      end
      S_SFD: begin
        state_d    = S_DATA;
        tx_en_d    = 1'b1;
        txd_d      = pay_s;
        tx_er_d    = armed_q | inject_err;
        armed_d    = 1'b0;
        gen_idx_d  = gen_idx_q + LEN_W'(1);
        gen_lfsr_d = lfsr_next(gen_lfsr_q);
      end
      S_DATA: begin
        if (gen_idx_q == len_eff_s) begin
          state_d     = S_IPG;
          cnt_d       = {PC_W{1'b0}};
          tx_frames_d = sat_inc(tx_frames_q);
        end else begin
          tx_en_d    = 1'b1;
          txd_d      = pay_s;
          gen_idx_d  = gen_idx_q + LEN_W'(1);
          gen_lfsr_d = lfsr_next(gen_lfsr_q);
        end
      end
      S_IPG: begin
        if (cnt_q == PC_W'(IPG_LEN - 1)) begin
          cnt_d = {PC_W{1'b0}};
          if (more_s && !stop) begin
            state_d = S_PRE;
            tx_en_d = 1'b1;
            txd_d   = 8'h55;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + PC_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // RX parser: preamble/SFD tracking, payload compare and per-frame error accounting
  always_comb begin
    rstate_d    = rstate_q;
    rx_idx_d    = rx_idx_q;
    rx_lfsr_d   = rx_lfsr_q;
    rx_cnt_d    = rx_cnt_q;
    rx_err_d    = rx_err_q;
    rx_frames_d = rx_frames_q;
    err_count_d = err_count_q;
    pre_byte_s  = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        if (dv_rise_s) begin
          rx_err_d   = RX_ER;
          pre_byte_s = 1'b1;
        end else begin
          rx_err_d = 1'b0;
        end
      end
      R_PRE: begin
        if (RX_DV) begin
          rx_err_d   = rx_err_q | RX_ER;
          pre_byte_s = 1'b1;
        end else begin
          rstate_d    = R_IDLE;
          err_count_d = sat_inc(err_count_q);
        end
      end
      R_DATA: begin
        if (RX_DV) begin
          rx_cnt_d  = (&rx_cnt_q) ? rx_cnt_q : rx_cnt_q + (LEN_W + 1)'(1);
          rx_err_d  = rx_err_q | RX_ER | (RXD != exp_s);
          rx_idx_d  = rx_idx_q + LEN_W'(1);
          rx_lfsr_d = lfsr_next(rx_lfsr_q);
        end else begin
          rstate_d = R_IDLE;
          if (rx_err_q || (rx_cnt_q != {1'b0, len_eff_s})) begin
            err_count_d = sat_inc(err_count_q);
          end else begin
            err_count_d = err_count_q;
          end
        end
      end
      R_DROP: begin
        if (!RX_DV) begin
          rstate_d    = R_IDLE;
          err_count_d = sat_inc(err_count_q);
        end else begin
          rstate_d = R_DROP;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
    if (pre_byte_s) begin
      if (RXD == 8'h55) begin
        rstate_d = R_PRE;
      end else if (RXD == 8'hD5) begin
        rstate_d    = R_DATA;
        rx_frames_d = sat_inc(rx_frames_q);
        rx_idx_d    = {LEN_W{1'b0}};
        rx_lfsr_d   = 8'hFF;
        rx_cnt_d    = {(LEN_W + 1){1'b0}};
      end else begin
        rstate_d = R_DROP;
      end
    end else begin
      rstate_d = rstate_d;
    end
    // a new run restarts all status counting
    if (clr_s) begin
      rx_frames_d = {CNT_W{1'b0}};
      err_count_d = {CNT_W{1'b0}};
    end else begin
      rx_frames_d = rx_frames_d;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge GTX_CLK) begin
    if (mr_main_reset) begin
      state_q     <= S_IDLE;
      rstate_q    <= R_IDLE;
      cnt_q       <= {PC_W{1'b0}};
      gen_idx_q   <= {LEN_W{1'b0}};
      gen_lfsr_q  <= 8'hFF;
      len_q       <= {LEN_W{1'b0}};
      num_q       <= {CNT_W{1'b0}};
      mode_q      <= 1'b0;
      armed_q     <= 1'b0;
      txd_q       <= 8'h00;
      tx_en_q     <= 1'b0;
      tx_er_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tx_frames_q <= {CNT_W{1'b0}};
      rx_frames_q <= {CNT_W{1'b0}};
      err_count_q <= {CNT_W{1'b0}};
      rx_idx_q    <= {LEN_W{1'b0}};
      rx_lfsr_q   <= 8'hFF;
      rx_cnt_q    <= {(LEN_W + 1){1'b0}};
      rx_err_q    <= 1'b0;
      rx_dv_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rstate_q    <= rstate_d;
      cnt_q       <= cnt_d;
      gen_idx_q   <= gen_idx_d;
      gen_lfsr_q  <= gen_lfsr_d;
      len_q       <= len_d;
      num_q       <= num_d;
      mode_q      <= mode_d;
      armed_q     <= armed_d;
      txd_q       <= txd_d;
      tx_en_q     <= tx_en_d;
      tx_er_q     <= tx_er_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tx_frames_q <= tx_frames_d;
      rx_frames_q <= rx_frames_d;
      err_count_q <= err_count_d;
      rx_idx_q    <= rx_idx_d;
      rx_lfsr_q   <= rx_lfsr_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_err_q    <= rx_err_d;
      rx_dv_q     <= RX_DV;
    end
  end

  assign TXD       = txd_q;
  assign TX_EN     = tx_en_q;
  assign TX_ER     = tx_er_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign tx_frames = tx_frames_q;
  assign rx_frames = rx_frames_q;
  assign err_count = err_count_q;

endmodule
